// File: rtl/pong_pkg.sv
// Shared types and encodings for the tennis game match sequencer.
package pong_pkg;

    localparam int SCORE_W = 4;

    // Match sequencer states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SERVE,
        ST_PLAY,
        ST_PAUSE,
        ST_OVER
    } state_t;

    // game_state encodings seen by the ball block and display
    localparam logic [1:0] GS_IDLE = 2'b00;
    localparam logic [1:0] GS_PLAY = 2'b01;
    localparam logic [1:0] GS_HOLD = 2'b10;
    localparam logic [1:0] GS_OVER = 2'b11;

    // winner encodings
    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    // Serve and pause both present as a hold to the ball block
    function automatic logic [1:0] state_to_gs(input state_t s);
        case (s)
            ST_SERVE: state_to_gs = GS_HOLD;
            ST_PLAY:  state_to_gs = GS_PLAY;
            ST_PAUSE: state_to_gs = GS_HOLD;
            ST_OVER:  state_to_gs = GS_OVER;
            default:  state_to_gs = GS_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, tick-based stable-level debounce,
// one-clk pulse on the debounced rising edge. A button held through reset
// gives no pulse until it has been seen released.
module btn_debounce #(
    parameter int DEBOUNCE_MS = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic tick_1ms,
    input  logic btn_in,
    output logic pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_MS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MS - 1);

    logic             sync_1;
    logic             sync_2;
    logic [1:0]       sync_vld;
    logic             level;
    logic             armed;
    logic [CNT_W-1:0] stable_cnt;
    logic             settle;

    // Level flips on the tick that completes DEBOUNCE_MS steady ticks
    assign settle = tick_1ms && (sync_2 != level) && (stable_cnt == CNT_LAST);

    // Synchronise the raw button and track when the pipeline holds real samples
    // NOTE: flops use non-blocking assignments so each one samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1   <= 1'b0;
            sync_2   <= 1'b0;
            sync_vld <= 2'b00;
        end else begin
            sync_1   <= btn_in;
            sync_2   <= sync_1;
            sync_vld <= {sync_vld[0], 1'b1};
        end
    end

    // Count steady ticks, update the debounced level, emit the press pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            level      <= 1'b0;
            armed      <= 1'b0;
            stable_cnt <= '0;
            pulse      <= 1'b0;
        end else begin
            pulse <= settle && sync_2 && armed;
            if (sync_vld[1] && !sync_2) begin
                armed <= 1'b1;
            end
            if (sync_2 == level) begin
                stable_cnt <= '0;
            end else if (tick_1ms) begin
                if (stable_cnt == CNT_LAST) begin
                    level      <= sync_2;
                    stable_cnt <= '0;
                end else begin
                    stable_cnt <= stable_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/game_controller.sv
// Match sequencer: buttons and score changes in, game_state / ball reset /
// winner / paused out. All outputs are registered from the next state.
module game_controller
    import pong_pkg::*;
#(
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_MS    = 1000,
    parameter int DEBOUNCE_MS = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1ms,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic [3:0] p1_score,
    input  logic [3:0] p2_score,
    output logic [1:0] game_state,
    output logic       ball_rst_n,
    output logic [1:0] winner,
    output logic       paused
);

    localparam int SC_W = $clog2(SERVE_MS + 1);
    localparam logic [SC_W-1:0]    SERVE_LOAD = SC_W'(SERVE_MS);
    localparam logic [SCORE_W-1:0] WIN_THR    = SCORE_W'(WIN_SCORE);

    state_t             state;
    state_t             next_state;
    logic [SC_W-1:0]    serve_cnt;
    logic [SCORE_W-1:0] p1_q;
    logic [SCORE_W-1:0] p2_q;
    logic               point_evt;
    logic               load_serve;
    logic [1:0]         winner_next;
    logic               start_pulse;
    logic               pause_pulse;

    btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_start_db (
        .clk      (clk),
        .reset    (reset),
        .tick_1ms (tick_1ms),
        .btn_in   (start_btn),
        .pulse    (start_pulse)
    );

    btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_pause_db (
        .clk      (clk),
        .reset    (reset),
        .tick_1ms (tick_1ms),
        .btn_in   (pause_btn),
        .pulse    (pause_pulse)
    );

    // Any change against last cycle's copy is a point event
    assign point_evt = (p1_score != p1_q) || (p2_score != p2_q);

    // Next-state, serve reload and winner selection
    // NOTE: every comb output gets a default first so no path infers a latch.
    always_comb begin
        next_state  = state;
        load_serve  = 1'b0;
        winner_next = winner;
        case (state)
            ST_IDLE: begin
                winner_next = WIN_NONE;
                if (start_pulse) begin
                    next_state = ST_SERVE;
                    load_serve = 1'b1;
                end
            end
            ST_SERVE: begin
                if (tick_1ms && serve_cnt == SC_W'(1)) begin
                    next_state = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (point_evt) begin
                    if (p1_score >= WIN_THR) begin
                        next_state  = ST_OVER;
                        winner_next = WIN_P1;
                    end else if (p2_score >= WIN_THR) begin
                        next_state  = ST_OVER;
                        winner_next = WIN_P2;
                    end else begin
                        next_state = ST_SERVE;
                        load_serve = 1'b1;
                    end
                end else if (pause_pulse) begin
                    next_state = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (pause_pulse || start_pulse) begin
                    next_state = ST_PLAY;
                end
            end
            ST_OVER: begin
                if (start_pulse) begin
                    next_state  = ST_IDLE;
                    winner_next = WIN_NONE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Score copies track the inputs every cycle, whatever the state
    always_ff @(posedge clk) begin
        if (reset) begin
            p1_q <= '0;
            p2_q <= '0;
        end else begin
            p1_q <= p1_score;
            p2_q <= p2_score;
        end
    end

    // Serve counter: loaded on SERVE entry, counts ticks down, parks at 0
    always_ff @(posedge clk) begin
        if (reset) begin
            serve_cnt <= '0;
        end else if (load_serve) begin
            serve_cnt <= SERVE_LOAD;
        end else if (state == ST_SERVE && tick_1ms && serve_cnt != '0) begin
            serve_cnt <= serve_cnt - SC_W'(1);
        end
    end

    // Registered outputs decoded from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            game_state <= GS_IDLE;
            ball_rst_n <= 1'b0;
            winner     <= WIN_NONE;
            paused     <= 1'b0;
        end else begin
            game_state <= state_to_gs(next_state);
            ball_rst_n <= (next_state != ST_IDLE);
            winner     <= winner_next;
            paused     <= (next_state == ST_PAUSE);
        end
    end

endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller: directed scenarios followed by random actions,
// all checked against a phase-level model of the match.
module tb_game_controller;
    import pong_pkg::*;

    localparam int WIN      = 3;
    localparam int SMS      = 5;
    localparam int DMS      = 20;
    localparam int TICK_DIV = 4;

    logic       clk;
    logic       reset;
    logic       tick_1ms;
    logic       start_btn;
    logic       pause_btn;
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    logic [1:0] game_state;
    logic       ball_rst_n;
    logic [1:0] winner;
    logic       paused;

    game_controller #(
        .WIN_SCORE   (WIN),
        .SERVE_MS    (SMS),
        .DEBOUNCE_MS (DMS)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .tick_1ms   (tick_1ms),
        .start_btn  (start_btn),
        .pause_btn  (pause_btn),
        .p1_score   (p1_score),
        .p2_score   (p2_score),
        .game_state (game_state),
        .ball_rst_n (ball_rst_n),
        .winner     (winner),
        .paused     (paused)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Match model: phase at action boundaries plus the latched winner
    typedef enum {M_IDLE, M_PLAY, M_PAUSE, M_OVER} phase_t;
    phase_t     m_phase;
    logic [1:0] m_winner;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // 1 ms tick: one clk in TICK_DIV, changed away from the edge
    int tick_div = 0;
    initial begin
        tick_1ms = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            tick_div = (tick_div + 1) % TICK_DIV;
            tick_1ms = (tick_div == 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Serve hold length: ticks seen while in serve hold until PLAY appears
    int   serve_ticks = 0;
    logic old_serve;
    logic new_serve;
    logic tk;
    initial begin
        forever begin
            @(posedge clk);
            old_serve = (game_state == GS_HOLD) && !paused;
            tk        = tick_1ms;
            #1;
            new_serve = (game_state == GS_HOLD) && !paused;
            if (old_serve && tk) serve_ticks++;
            if (old_serve && game_state == GS_PLAY) check("serve_len", serve_ticks, SMS);
            if (!new_serve) serve_ticks = 0;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [1:0] gs_of(input phase_t ph);
        case (ph)
            M_PLAY:  return GS_PLAY;
            M_PAUSE: return GS_HOLD;
            M_OVER:  return GS_OVER;
            default: return GS_IDLE;
        endcase
    endfunction

    task automatic cyc();
        @(posedge clk);
        #3;
    endtask

    task automatic wait_ticks(input int n);
        int seen = 0;
        while (seen < n) begin
            cyc();
            if (tick_1ms) seen++;
        end
    endtask

    task automatic wait_gs(input logic [1:0] exp, input int max_ticks, input string tag);
        int seen = 0;
        while (game_state !== exp && seen < max_ticks) begin
            cyc();
            if (tick_1ms) seen++;
        end
        check(tag, game_state, exp);
    endtask

    task automatic check_model(input string tag);
        check({tag, "_gs"},     game_state, gs_of(m_phase));
        check({tag, "_rstn"},   ball_rst_n, m_phase != M_IDLE);
        check({tag, "_win"},    winner,     m_winner);
        check({tag, "_paused"}, paused,     m_phase == M_PAUSE);
    endtask

    task automatic bump(input int player, output bit changed);
        changed = 1'b0;
        if (player == 1) begin
            if (p1_score != 4'd15) begin
                p1_score = p1_score + 4'd1;
                changed  = 1'b1;
            end
        end else begin
            if (p2_score != 4'd15) begin
                p2_score = p2_score + 4'd1;
                changed  = 1'b1;
            end
        end
    endtask

    // Win rule applied to a point event in PLAY; player 1 checked first
    task automatic model_point(output logic [1:0] exp_now);
        if (p1_score >= WIN) begin
            m_phase  = M_OVER;
            m_winner = WIN_P1;
            exp_now  = GS_OVER;
        end else if (p2_score >= WIN) begin
            m_phase  = M_OVER;
            m_winner = WIN_P2;
            exp_now  = GS_OVER;
        end else begin
            exp_now  = GS_HOLD;
        end
    endtask

    task automatic press(input int sel, input int hold);
        logic [1:0] gs_before;
        gs_before = gs_of(m_phase);
        if (sel == 0) start_btn = 1'b1;
        else          pause_btn = 1'b1;
        wait_ticks(DMS - 2);
        check("press_early", game_state, gs_before);
        wait_ticks(hold - (DMS - 2));
        start_btn = 1'b0;
        pause_btn = 1'b0;
        wait_ticks(DMS + 3);
        if (sel == 0) begin
            case (m_phase)
                M_IDLE:  begin m_phase = M_PLAY; m_winner = WIN_NONE; end
                M_PAUSE: m_phase = M_PLAY;
                M_OVER:  begin
                    m_phase  = M_IDLE;
                    m_winner = WIN_NONE;
                    p1_score = 4'd0;
                    p2_score = 4'd0;
                end
                default: ;
            endcase
        end else begin
            case (m_phase)
                M_PLAY:  m_phase = M_PAUSE;
                M_PAUSE: m_phase = M_PLAY;
                default: ;
            endcase
        end
        cyc();
        check_model(sel == 0 ? "start" : "pause");
    endtask

    task automatic glitch(input int sel);
        if (sel == 0) start_btn = 1'b1;
        else          pause_btn = 1'b1;
        wait_ticks(5);
        start_btn = 1'b0;
        pause_btn = 1'b0;
        wait_ticks(DMS + 3);
        check_model("glitch");
    endtask

    task automatic do_point(input int player, input bit dbl);
        bit         ch;
        bit         evt;
        logic [1:0] exp_now;
        evt = 1'b0;
        ch  = 1'b0;
        if (m_phase != M_IDLE) bump(player, ch);
        if (m_phase == M_PLAY && ch) begin
            evt = 1'b1;
            model_point(exp_now);
        end
        cyc();
        if (evt) check("pt_next", game_state, exp_now);
        if (dbl && evt) begin
            wait_ticks(1);
            bump($urandom_range(1, 2), ch);
        end
        wait_ticks(SMS + 3);
        check_model("point");
    endtask

    initial begin
        bit         ch;
        bit         seen_pulse;
        logic [1:0] exp_now;

        reset     = 1'b1;
        start_btn = 1'b0;
        pause_btn = 1'b0;
        p1_score  = 4'd0;
        p2_score  = 4'd0;
        m_phase   = M_IDLE;
        m_winner  = WIN_NONE;
        repeat (3) cyc();
        check_model("reset");
        reset = 1'b0;
        repeat (4) cyc();
        check_model("post_rst");

        // Short glitch on start in IDLE
        glitch(0);

        // Start held 25 ticks: ball reset low until serve entry, then 5-tick hold
        start_btn = 1'b1;
        wait_ticks(DMS - 2);
        check("rstn_low_early", ball_rst_n, 1'b0);
        wait_gs(GS_HOLD, 6, "serve_entry");
        check("rstn_serve", ball_rst_n, 1'b1);
        check("serve_not_paused", paused, 1'b0);
        wait_gs(GS_PLAY, SMS + 2, "serve_to_play");
        wait_ticks(2);
        start_btn = 1'b0;
        wait_ticks(DMS + 3);
        m_phase = M_PLAY;
        check_model("first_play");

        // Player 2 point
        do_point(2, 1'b0);

        // Pause and resume
        press(1, DMS + 3);
        press(1, DMS + 3);

        // Start pressed while serving is ignored
        bump(1, ch);
        cyc();
        check("serve_hold", game_state, GS_HOLD);
        press(0, DMS + 3);

        // Pause pulse and point in the same cycle: point wins, pause dropped
        pause_btn  = 1'b1;
        seen_pulse = 1'b0;
        for (int i = 0; i < (DMS + 8) * TICK_DIV && !seen_pulse; i++) begin
            cyc();
            if (u_dut.pause_pulse) seen_pulse = 1'b1;
        end
        check("pause_pulse_seen", seen_pulse, 1'b1);
        bump(2, ch);
        model_point(exp_now);
        cyc();
        check("pp_gs", game_state, exp_now);
        check("pp_paused", paused, 1'b0);
        wait_ticks(2);
        pause_btn = 1'b0;
        wait_ticks(DMS + 3);
        check_model("pause_drop");

        // Player 1 reaches WIN_SCORE, then start returns to IDLE
        do_point(1, 1'b0);
        do_point(1, 1'b0);
        check("p1_wins", winner, WIN_P1);
        press(0, DMS + 3);

        // Both at or over WIN_SCORE on one event: player 1 has priority
        press(0, DMS + 3);
        press(1, DMS + 3);
        p1_score = 4'd3;
        p2_score = 4'd2;
        cyc();
        check("pause_silent", game_state, GS_HOLD);
        wait_ticks(2);
        check_model("pause_silent");
        press(1, DMS + 3);
        do_point(2, 1'b0);
        check("prio_p1", winner, WIN_P1);
        press(0, DMS + 3);

        // Reset in SERVE with a score change pending
        press(0, DMS + 3);
        bump(1, ch);
        cyc();
        check("pre_rst_hold", game_state, GS_HOLD);
        bump(2, ch);
        reset = 1'b1;
        cyc();
        reset    = 1'b0;
        m_phase  = M_IDLE;
        m_winner = WIN_NONE;
        check_model("mid_rst");
        p1_score = 4'd0;
        p2_score = 4'd0;
        wait_ticks(2);
        check_model("after_rst");

        // Random actions against the model
        for (int n = 0; n < 30; n++) begin
            int act;
            act = $urandom_range(0, 9);
            if (act <= 2)      press(0, DMS + 3);
            else if (act <= 4) press(1, DMS + 3);
            else if (act <= 7) do_point($urandom_range(1, 2), 1'b0);
            else if (act == 8) do_point($urandom_range(1, 2), 1'b1);
            else               glitch($urandom_range(0, 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
